// File: rtl/seq_barrel_shifter.sv
// Iterative barrel shifter: shifts one bit position per cycle. Left, logical-right
// and arithmetic-right results match the single-cycle combinational shifter.
module seq_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             dir,
  input  logic             tp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake rules:
  // - A request transfers on a rising edge where in_valid && in_ready.
  // - A result transfers on a rising edge where out_valid && out_ready.
  // - in_ready, out_valid and busy decode from state only, never from inputs.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;  // {dir, tp}

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dout_d  = din;
          cnt_d   = shamt;
          mode_d  = {dir, tp};
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (mode_q[1]) begin
          dout_d = {dout_q[WIDTH-2:0], 1'b0};
        end else if (mode_q[0]) begin
          dout_d = {1'b0, dout_q[WIDTH-1:1]};
        end else begin
          // Replicating the MSB each step accumulates the signed shift of the operand.
          dout_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign dout        = dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Directed bench for seq_barrel_shifter: hand-computed vectors, latency and
// backpressure checks, asynchronous reset mid-shift, plus a reference-model sweep.
module tb_seq_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       dir;
  logic       tp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  seq_barrel_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din         (din),
    .shamt       (shamt),
    .dir         (dir),
    .tp          (tp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic dr, input logic t);
    logic signed [7:0] sd;
    sd = d;
    if (dr) return d << s;
    else if (t) return d >> s;
    else return sd >>> s;
  endfunction

  // Driver: called at a negedge with the DUT in IDLE. Checks latency, result,
  // busy, and stability under a stall while the request inputs churn.
  task automatic run_req(input string tag, input logic [7:0] d, input logic [2:0] s,
                         input logic dr, input logic t, input logic [7:0] exp,
                         input int stall);
    int   lat;
    logic busy_ok;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    din       = d;
    shamt     = s;
    dir       = dr;
    tp        = t;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    din      = 8'($urandom);
    shamt    = 3'($urandom);
    dir      = 1'($urandom);
    tp       = 1'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 20) begin
      busy_ok = busy_ok & busy & ~in_ready;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 32'(s));
    check({tag, "_busy_in_flight"}, busy_ok & busy, 1);
    check({tag, "_dout"}, dout, exp);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      din      = 8'($urandom);
      shamt    = 3'($urandom);
      @(negedge clk);
      check({tag, "_stall_dout"}, dout, exp);
      check({tag, "_stall_out_valid"}, out_valid, 1);
      check({tag, "_stall_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din       = 8'h00;
    shamt     = 3'd0;
    dir       = 1'b0;
    tp        = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_dout", dout, 8'h00);
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("left3",      8'hB5, 3'd3, 1'b1, 1'b0, 8'hA8, 0);
    run_req("lsr3",       8'hB5, 3'd3, 1'b0, 1'b1, 8'h16, 0);
    run_req("asr3",       8'hB5, 3'd3, 1'b0, 1'b0, 8'hF6, 1);
    run_req("left3_tp1",  8'hB5, 3'd3, 1'b1, 1'b1, 8'hA8, 0);
    run_req("sh0_left",   8'hB5, 3'd0, 1'b1, 1'b0, 8'hB5, 0);
    run_req("sh0_asr",    8'hB5, 3'd0, 1'b0, 1'b0, 8'hB5, 0);
    run_req("asr7",       8'h80, 3'd7, 1'b0, 1'b0, 8'hFF, 0);
    run_req("lsr7",       8'h80, 3'd7, 1'b0, 1'b1, 8'h01, 0);
    run_req("left7",      8'h01, 3'd7, 1'b1, 1'b0, 8'h80, 0);
    run_req("backpress",  8'h3C, 3'd2, 1'b1, 1'b0, 8'hF0, 5);
    run_req("after_bp",   8'h96, 3'd1, 1'b0, 1'b0, 8'hCB, 0);

    // Asynchronous reset in the middle of a 6-step shift.
    in_valid = 1'b1;
    din      = 8'hB5;
    shamt    = 3'd6;
    dir      = 1'b1;
    tp       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_shift_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 8'h00);
    check("async_rst_flags", {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req("post_rst", 8'hB5, 3'd3, 1'b1, 1'b0, 8'hA8, 0);

    // Reference-model sweep with random operands and stalls.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] rd;
      logic [2:0] rs;
      logic       rdir;
      logic       rtp;
      rd   = 8'($urandom);
      rs   = 3'($urandom_range(0, 7));
      rdir = 1'($urandom_range(0, 1));
      rtp  = 1'($urandom_range(0, 1));
      run_req("rand", rd, rs, rdir, rtp, ref_shift(rd, rs, rdir, rtp), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
